// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg: shared state encoding, default widths and counter sizing for the fixed-point divider
package fxp_div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_e;
  localparam int DVD_W_DEF  = 16;
  localparam int DVS_W_DEF  = 8;
  localparam int FRAC_W_DEF = 8;
  function automatic int cnt_w(input int q_w);
    return $clog2(q_w + 2);
  endfunction
endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational restoring shift-subtract iteration
module fxp_div_step #(
  parameter int DVS_W = 8
) (
  input  logic [DVS_W:0]   rem_i,
  input  logic             bit_i,
  input  logic [DVS_W-1:0] dvs_i,
  output logic [DVS_W:0]   rem_o,
  output logic             q_o
);
  logic [DVS_W+1:0] partial;
  logic [DVS_W:0]   diff;
  assign partial = {rem_i, bit_i};
  assign q_o     = partial >= {2'b00, dvs_i};
  // when the subtract is taken the true result is below the divisor, so the low bits suffice
  assign diff    = partial[DVS_W:0] - {1'b0, dvs_i};
  assign rem_o   = q_o ? diff : partial[DVS_W:0];
endmodule

// File: rtl/fxp_seq_divider.sv
// fxp_seq_divider: sequential restoring divider, Quotient = Dividend*2^FRAC_W/Divisor
// with optional half-LSB rounding from a guard bit and divide-by-zero flagging.
module fxp_seq_divider
  import fxp_div_pkg::*;
#(
  parameter int DVD_W  = DVD_W_DEF,
  parameter int DVS_W  = DVS_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      RoundEn,
  input  logic [DVD_W-1:0]          Dividend,
  input  logic [DVS_W-1:0]          Divisor,
  output logic [DVD_W+FRAC_W-1:0]   Quotient,
  output logic                      DivZero,
  output logic                      Busy,
  output logic                      Ack
);
  localparam int Q_W = DVD_W + FRAC_W;
  localparam int CW  = cnt_w(Q_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(Q_W);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DVS_W:0]   rem_q, rem_d, step_rem;
  logic [Q_W:0]     sh_q, sh_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [Q_W-1:0]   quo_q, quo_d;
  logic             rnd_q, rnd_d, dz_q, dz_d, busy_q, busy_d, ack_q, ack_d, step_q;

  fxp_div_step #(.DVS_W(DVS_W)) u_step (
    .rem_i (rem_q),
    .bit_i (sh_q[Q_W]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // sh_q shifts the extended dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rnd_d   = rnd_q;
    dz_d    = dz_q;
    busy_d  = ack_q ? 1'b0 : busy_q;
    ack_d   = state_q == DONE;
    case (state_q)
      IDLE: if (Start) begin
        sh_d   = {Dividend, {(FRAC_W+1){1'b0}}};
        dvs_d  = Divisor;
        rnd_d  = RoundEn;
        dz_d   = 1'b0;
        busy_d = 1'b1;
        cnt_d  = '0;
        rem_d  = '0;
        if (Divisor == '0) begin
          state_d = DONE;
          quo_d   = '1;
          dz_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        sh_d    = {sh_q[Q_W-1:0], step_q};
        rem_d   = step_rem;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_LAST ? FIN : RUN;
      end
      FIN: begin
        quo_d   = sh_q[Q_W:1] + Q_W'(rnd_q & sh_q[0]);
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rnd_q   <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rnd_q   <= rnd_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign Quotient = quo_q;
  assign DivZero  = dz_q;
  assign Busy     = busy_q;
  assign Ack      = ack_q;
endmodule

// File: tb/tb_fxp_seq_divider.sv
// tb_fxp_seq_divider: directed vectors with a scoreboard queue popped on every Ack
module tb_fxp_seq_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        round_en = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [23:0] quotient;
  logic        div_zero, busy, ack;

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] sb_q[$];

  fxp_seq_divider dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .Start    (start),
    .RoundEn  (round_en),
    .Dividend (dividend),
    .Divisor  (divisor),
    .Quotient (quotient),
    .DivZero  (div_zero),
    .Busy     (busy),
    .Ack      (ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (ack) begin
    if (sb_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
    else begin
      logic [24:0] e;
      e = sb_q.pop_front();
      chk("quotient", {8'd0, quotient}, {8'd0, e[23:0]});
      chk("divzero", {31'd0, div_zero}, {31'd0, e[24]});
    end
  end

  // mode 0: plain op, 1: re-Start with new operands mid-run, 2: reset abort mid-run
  task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, input logic rnd,
                        input logic [23:0] exp_q, input logic exp_dz, input int exp_lat,
                        input int mode);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    dividend = dvd; divisor = dvs; round_en = rnd; start = 1'b1;
    if (mode != 2) sb_q.push_back({exp_dz, exp_q});
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1 n++;
      if (mode == 1 && n == 10) begin start = 1'b1; dividend = 16'd9; divisor = 8'd2; round_en = 1'b1; end
      if (mode == 1 && n == 11) start = 1'b0;
      if (mode == 2 && n == 12) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_quotient", {8'd0, quotient}, 32'd0);
        chk("abort_divzero", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (ack) break;
    end
    chk("ack_latency", n, exp_lat);
    @(posedge clk);
    #1;
    chk("ack_width", {31'd0, ack}, 32'd0);
    chk("busy_after_ack", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_quotient", {8'd0, quotient}, 32'd0);
    chk("rst_divzero", {31'd0, div_zero}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    rst_n = 1'b1;
    run_op(16'd3,      8'hFF, 1'b0, 24'h000003, 1'b0, 27, 0);
    run_op(16'd2,      8'd3,  1'b0, 24'h0000AA, 1'b0, 27, 0);
    run_op(16'd2,      8'd3,  1'b1, 24'h0000AB, 1'b0, 27, 0);
    run_op(16'd1,      8'd3,  1'b1, 24'h000055, 1'b0, 27, 0);
    run_op(16'hFFFF,   8'h01, 1'b1, 24'hFFFF00, 1'b0, 27, 0);
    run_op(16'd0,      8'h7F, 1'b0, 24'h000000, 1'b0, 27, 0);
    run_op(16'h1234,   8'h00, 1'b0, 24'hFFFFFF, 1'b1, 1,  0);
    run_op(16'd10,     8'd5,  1'b0, 24'h000200, 1'b0, 27, 0);
    run_op(16'd2,      8'd3,  1'b0, 24'h0000AA, 1'b0, 27, 1);
    run_op(16'd3,      8'hFF, 1'b0, 24'h000003, 1'b0, 27, 2);
    run_op(16'd3,      8'hFF, 1'b0, 24'h000003, 1'b0, 27, 0);
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
